// File: rtl/game_ctrl.sv
// Game controller: start/collision/hit-stop state machine with frame
// stepping, lives and saturating score. Outputs are registered and change
// on the clock edge that ends a frame_start or start_pe cycle.
//
// Handshake note: there is no valid/ready handshake in this block. start_pe
// and frame_start are single-cycle event strobes. Each one is acted on in
// the cycle it is high and is never held or queued.
module game_ctrl #(
    parameter int HITSTOP_FRAMES = 30,
    parameter int SCORE_DIV      = 6,
    parameter int START_LIVES    = 3,
    parameter int SCORE_MAX      = 999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       video_on,
    input  logic       goose_px,
    input  logic       bean_px,
    input  logic       start_btn,
    output logic [1:0] state,
    output logic       frame_step,
    output logic       obj_clear,
    output logic       hit_flag,
    output logic [1:0] lives,
    output logic [9:0] score
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_HITSTOP = 2'd2;
    localparam logic [1:0] S_OVER    = 2'd3;

    localparam int HW = $clog2(HITSTOP_FRAMES + 1);
    localparam int DW = $clog2(SCORE_DIV + 1);

    logic          start_s1, start_s2, start_s3;
    logic          vsync_q;
    logic          start_pe, frame_start, coll_now, coll_seen;
    logic [HW-1:0] hs_cnt;
    logic [DW-1:0] div_cnt;
    logic [1:0]    state_next;

    assign start_pe    = start_s2 & ~start_s3;
    assign frame_start = vsync_q & ~vsync;
    assign coll_now    = (state == S_RUN) & video_on & goose_px & bean_px;

    // Next-state decision; lives==1 in RUN means the coming decrement ends the game.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_OVER: if (start_pe) state_next = S_RUN;
            S_RUN:          if (frame_start && coll_seen)
                                state_next = (lives == 2'd1) ? S_OVER : S_HITSTOP;
            S_HITSTOP:      if (frame_start && hs_cnt == '0) state_next = S_RUN;
            default:        state_next = S_IDLE;
        endcase
    end

    // Input synchronizers, edge-detect registers and all game state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_s3   <= 1'b0;
            vsync_q    <= 1'b1;
            state      <= S_IDLE;
            frame_step <= 1'b0;
            obj_clear  <= 1'b0;
            hit_flag   <= 1'b0;
            lives      <= 2'(START_LIVES);
            score      <= '0;
            hs_cnt     <= '0;
            div_cnt    <= '0;
            coll_seen  <= 1'b0;
        end else begin
            start_s1   <= start_btn;
            start_s2   <= start_s1;
            start_s3   <= start_s2;
            vsync_q    <= vsync;
            state      <= state_next;
            hit_flag   <= (state_next == S_HITSTOP);
            frame_step <= 1'b0;
            obj_clear  <= 1'b0;

            // A frame_start closes the current frame, so a collision seen in
            // that same cycle is carried into the next frame.
            if (state_next != state)
                coll_seen <= 1'b0;
            else if (frame_start)
                coll_seen <= coll_now;
            else if (coll_now)
                coll_seen <= 1'b1;

            case (state)
                S_IDLE, S_OVER: begin
                    if (start_pe) begin
                        lives     <= 2'(START_LIVES);
                        score     <= '0;
                        div_cnt   <= '0;
                        hs_cnt    <= '0;
                        obj_clear <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (frame_start) begin
                        if (coll_seen) begin
                            lives  <= lives - 2'd1;
                            hs_cnt <= HW'(HITSTOP_FRAMES - 1);
                        end else begin
                            frame_step <= 1'b1;
                            if (div_cnt == DW'(SCORE_DIV - 1)) begin
                                div_cnt <= '0;
                                if (score != 10'(SCORE_MAX))
                                    score <= score + 10'd1;
                            end else begin
                                div_cnt <= div_cnt + DW'(1);
                            end
                        end
                    end
                end
                S_HITSTOP: begin
                    if (frame_start) begin
                        if (hs_cnt == '0)
                            obj_clear <= 1'b1;
                        else
                            hs_cnt <= hs_cnt - HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl with hand-computed expectations.
module tb_game_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic       video_on = 1'b0;
    logic       goose_px = 1'b0;
    logic       bean_px = 1'b0;
    logic       start_btn = 1'b0;
    logic [1:0] state;
    logic       frame_step, obj_clear, hit_flag;
    logic [1:0] lives;
    logic [9:0] score;

    int n_checks = 0;
    int n_errors = 0;
    int fs_cnt = 0;
    int oc_cnt = 0;
    int fs0, oc0;

    game_ctrl dut (
        .clk(clk), .reset(rst_n), .vsync(vsync), .video_on(video_on),
        .goose_px(goose_px), .bean_px(bean_px), .start_btn(start_btn),
        .state(state), .frame_step(frame_step), .obj_clear(obj_clear),
        .hit_flag(hit_flag), .lives(lives), .score(score)
    );

    // clock
    always #5 clk = ~clk;

    // pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_step) fs_cnt <= fs_cnt + 1;
        if (obj_clear)  oc_cnt <= oc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver: n frames, each a 2-cycle vsync low/high
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) vsync = 1'b0;
            @(negedge clk) vsync = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic press_start();
        @(negedge clk) start_btn = 1'b1;
        repeat (4) @(negedge clk);
        start_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic overlap_cycle(input logic vis);
        @(negedge clk) begin video_on = vis; goose_px = 1'b1; bean_px = 1'b1; end
        @(negedge clk) begin video_on = 1'b0; goose_px = 1'b0; bean_px = 1'b0; end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_lives", lives, 3);
        check("rst_score", score, 0);
        check("rst_hit", hit_flag, 0);
        check("rst_fstep", frame_step, 0);
        check("rst_oclr", obj_clear, 0);
        @(negedge clk) rst_n = 1'b1;

        // start
        oc0 = oc_cnt;
        press_start();
        check("start_state", state, 1);
        check("start_lives", lives, 3);
        check("start_score", score, 0);
        check("start_oclr_once", oc_cnt - oc0, 1);

        // 12 frames without collision
        fs0 = fs_cnt;
        frames(12);
        check("run12_steps", fs_cnt - fs0, 12);
        check("run12_score", score, 2);

        // overlap outside visible area is not a collision
        overlap_cycle(1'b0);
        frames(1);
        check("novis_state", state, 1);

        // visible overlap -> hit-stop
        overlap_cycle(1'b1);
        frames(1);
        check("hit1_state", state, 2);
        check("hit1_lives", lives, 2);
        check("hit1_flag", hit_flag, 1);
        check("hit1_score_hold", score, 2);
        fs0 = fs_cnt;
        oc0 = oc_cnt;
        overlap_cycle(1'b1);
        frames(29);
        check("hs29_state", state, 2);
        check("hs29_nostep", fs_cnt - fs0, 0);
        check("hs29_lives", lives, 2);
        frames(1);
        check("hs30_state", state, 1);
        check("hs30_oclr", oc_cnt - oc0, 1);
        check("hs30_nostep", fs_cnt - fs0, 0);
        check("hs30_hit", hit_flag, 0);

        // start ignored in RUN
        oc0 = oc_cnt;
        press_start();
        check("run_start_state", state, 1);
        check("run_start_lives", lives, 2);
        check("run_start_oclr", oc_cnt - oc0, 0);

        // overlap coincident with frame_start counts toward the next frame
        fs0 = fs_cnt;
        @(negedge clk) begin vsync = 1'b0; video_on = 1'b1; goose_px = 1'b1; bean_px = 1'b1; end
        @(negedge clk) begin vsync = 1'b1; video_on = 1'b0; goose_px = 1'b0; bean_px = 1'b0; end
        @(negedge clk);
        check("coin_state", state, 1);
        check("coin_step", fs_cnt - fs0, 1);
        frames(1);
        check("hit2_state", state, 2);
        check("hit2_lives", lives, 1);
        frames(30);
        check("hit2_back", state, 1);

        // third collision -> game over
        overlap_cycle(1'b1);
        frames(1);
        check("hit3_state", state, 3);
        check("hit3_lives", lives, 0);
        check("hit3_hit", hit_flag, 0);
        fs0 = fs_cnt;
        overlap_cycle(1'b1);
        frames(5);
        check("over_nostep", fs_cnt - fs0, 0);
        check("over_state", state, 3);

        // restart from OVER
        press_start();
        check("restart_state", state, 1);
        check("restart_lives", lives, 3);
        check("restart_score", score, 0);

        // saturation: 5988 frames = 998 increments, then 12 more
        frames(5988);
        check("score_998", score, 998);
        frames(12);
        check("score_sat", score, 999);

        // async reset mid-hitstop
        overlap_cycle(1'b1);
        frames(3);
        check("pre_rst_state", state, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_hit", hit_flag, 0);
        check("arst_lives", lives, 3);
        check("arst_score", score, 0);
        @(negedge clk) rst_n = 1'b1;
        overlap_cycle(1'b1);
        overlap_cycle(1'b1);
        frames(2);
        check("idle_lives", lives, 3);
        check("idle_state", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
